// File: rtl/stdout_uart_tx.sv
// stdout_uart_tx: captures bytes from the core's stdout/stdout_en stream into a
// small FIFO and serialises them as UART 8N1 on tx.
//
// Ports:
//   clk        - clock, all logic on posedge
//   reset      - asynchronous active-low reset
//   stdout     - byte from core, sampled on the stdout_en rising edge
//   stdout_en  - byte-present strobe; one push per rising edge
//   tx         - registered UART line, idle high
//   busy       - high while a frame is in flight or bytes are buffered
//   fifo_count - bytes buffered, excluding the one being sent
//   overflow   - sticky flag, set when a byte is dropped on a full FIFO
module stdout_uart_tx #(
    parameter int unsigned CLK_DIV         = 16,
    parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 stdout,
    input  logic                       stdout_en,
    output logic                       tx,
    output logic                       busy,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
    output logic                       overflow
);

    localparam int unsigned AW     = FIFO_ADDR_WIDTH;
    localparam int unsigned DEPTH  = 1 << AW;
    localparam int unsigned CNT_W  = AW + 1;
    localparam int unsigned BAUD_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                en_q;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          mem [DEPTH];

    logic push_c;
    logic pop_c;
    logic wr_en_c;
    logic full_c;
    logic last_tick_c;

    // FIFO control: a pop frees a slot in the same cycle, so push-on-full
    // is only dropped when no pop accompanies it.
    always_comb begin
        push_c      = stdout_en & ~en_q;
        full_c      = (count_q == CNT_W'(DEPTH));
        last_tick_c = (baud_q == BAUD_W'(CLK_DIV - 1));
        pop_c       = (count_q != '0) &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && last_tick_c));
        wr_en_c     = push_c && (!full_c || pop_c);
        ovf_d       = ovf_q | (push_c & full_c & ~pop_c);
        count_d     = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
        wr_ptr_d    = wr_en_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end

    // Transmit FSM; tx_d depends on the current state so tx lags the state
    // by one cycle, giving the two-cycle push-to-start-bit latency.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop_c) begin
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (last_tick_c) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (last_tick_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (last_tick_c) begin
                    baud_d = '0;
                    if (pop_c) begin
                        shift_d = mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    // State and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            en_q     <= stdout_en;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage, no reset needed: pointers and count gate every access
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q] <= stdout;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed testbench for stdout_uart_tx (CLK_DIV=4, depth 4).
// Each run drives a per-cycle strobe schedule, logs outputs 1 time unit
// after every posedge, then checks the logs against hand-derived frames.
module tb_stdout_uart_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned AW      = 2;
    localparam int          LOG_N   = 256;

    logic          clk;
    logic          reset;
    logic [7:0]    stdout;
    logic          stdout_en;
    logic          tx;
    logic          busy;
    logic [AW:0]   fifo_count;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    int mx;

    logic        tx_log   [LOG_N];
    logic        busy_log [LOG_N];
    logic        ovf_log  [LOG_N];
    int          cnt_log  [LOG_N];
    logic        en_sch   [LOG_N];
    logic [7:0]  val_sch  [LOG_N];

    stdout_uart_tx #(
        .CLK_DIV         (CLK_DIV),
        .FIFO_ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stdout     (stdout),
        .stdout_en  (stdout_en),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sch();
        for (int i = 0; i < LOG_N; i++) begin
            en_sch[i]  = 1'b0;
            val_sch[i] = 8'h00;
        end
    endtask

    task automatic strobe(input int at, input int len, input logic [7:0] v);
        for (int i = at; i < at + len; i++) begin
            en_sch[i]  = 1'b1;
            val_sch[i] = v;
        end
    endtask

    // Log index c holds outputs just after the c-th posedge of the run
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            stdout_en = en_sch[c];
            stdout    = val_sch[c];
            @(posedge clk);
            #1;
            tx_log[c]   = tx;
            busy_log[c] = busy;
            ovf_log[c]  = overflow;
            cnt_log[c]  = int'(fifo_count);
        end
        stdout_en = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int start, input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * int'(CLK_DIV); i++) begin
            chk($sformatf("%s_tx%0d", tag, i), 32'(tx_log[start + i]), 32'(fr[i / int'(CLK_DIV)]));
        end
    endtask

    task automatic chk_idle(input string tag, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            chk($sformatf("%s_idle%0d", tag, i), 32'(tx_log[i]), 32'd1);
        end
    endtask

    initial begin
        reset     = 1'b0;
        stdout    = 8'h00;
        stdout_en = 1'b0;
        clear_sch();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single byte 0x48
        clear_sch();
        strobe(0, 1, 8'h48);
        run(50);
        chk("one_cnt0", 32'(cnt_log[0]), 32'd1);
        chk("one_cnt1", 32'(cnt_log[1]), 32'd0);
        chk("one_busy0", 32'(busy_log[0]), 32'd1);
        chk("one_busy40", 32'(busy_log[40]), 32'd1);
        chk("one_busy41", 32'(busy_log[41]), 32'd0);
        chk("one_tx0", 32'(tx_log[0]), 32'd1);
        chk("one_tx1", 32'(tx_log[1]), 32'd1);
        chk_frame("one", 2, 8'h48);
        chk_idle("one", 42, 49);

        // Back-to-back "Hi"
        clear_sch();
        strobe(0, 1, 8'h48);
        strobe(4, 1, 8'h69);
        run(90);
        mx = 0;
        for (int i = 0; i < 90; i++) if (cnt_log[i] > mx) mx = cnt_log[i];
        chk("hi_maxcnt", 32'(mx), 32'd1);
        chk("hi_cnt4", 32'(cnt_log[4]), 32'd1);
        chk("hi_cnt41", 32'(cnt_log[41]), 32'd0);
        chk_frame("hi0", 2, 8'h48);
        chk_frame("hi1", 42, 8'h69);
        chk("hi_busy80", 32'(busy_log[80]), 32'd1);
        chk("hi_busy81", 32'(busy_log[81]), 32'd0);
        chk_idle("hi", 82, 89);

        // Strobe held high for 50 cycles
        clear_sch();
        strobe(0, 50, 8'h41);
        run(60);
        mx = 0;
        for (int i = 1; i < 60; i++) if (cnt_log[i] > mx) mx = cnt_log[i];
        chk("held_maxcnt", 32'(mx), 32'd0);
        chk_frame("held", 2, 8'h41);
        chk_idle("held", 42, 59);

        // Overflow: six strobes two cycles apart into a depth-4 FIFO
        clear_sch();
        for (int k = 0; k < 6; k++) strobe(2 * k, 1, 8'(k + 1));
        run(210);
        chk("ovf_cnt8", 32'(cnt_log[8]), 32'd4);
        chk("ovf_cnt10", 32'(cnt_log[10]), 32'd4);
        chk("ovf_flag9", 32'(ovf_log[9]), 32'd0);
        chk("ovf_flag10", 32'(ovf_log[10]), 32'd1);
        chk("ovf_cnt41", 32'(cnt_log[41]), 32'd3);
        for (int k = 0; k < 5; k++) chk_frame($sformatf("ovf%0d", k + 1), 2 + 40 * k, 8'(k + 1));
        chk_idle("ovf", 202, 209);
        chk("ovf_cnt201", 32'(cnt_log[201]), 32'd0);
        chk("ovf_busy201", 32'(busy_log[201]), 32'd0);
        chk("ovf_flag209", 32'(ovf_log[209]), 32'd1);

        // Reset asserted mid-frame during data bit 3 (0xF7 has bit 3 = 0)
        clear_sch();
        strobe(0, 1, 8'hF7);
        strobe(2, 1, 8'h33);
        run(20);
        chk("mid_tx_bit3", 32'(tx), 32'd0);
        chk("mid_cnt", 32'(fifo_count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_async_tx", 32'(tx), 32'd1);
        chk("mid_async_cnt", 32'(fifo_count), 32'd0);
        chk("mid_async_busy", 32'(busy), 32'd0);
        chk("mid_async_ovf", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_sch();
        strobe(0, 1, 8'h55);
        run(50);
        chk("post_tx0", 32'(tx_log[0]), 32'd1);
        chk("post_tx1", 32'(tx_log[1]), 32'd1);
        chk("post_cnt0", 32'(cnt_log[0]), 32'd1);
        chk_frame("post", 2, 8'h55);
        chk_idle("post", 42, 49);

        // Full FIFO with a push on the STOP->START pop edge
        clear_sch();
        for (int k = 0; k < 5; k++) strobe(2 * k, 1, 8'hA0 + 8'(k));
        strobe(41, 1, 8'hA5);
        run(250);
        chk("full_cnt40", 32'(cnt_log[40]), 32'd4);
        chk("full_cnt41", 32'(cnt_log[41]), 32'd4);
        chk("full_ovf41", 32'(ovf_log[41]), 32'd0);
        chk("full_cnt81", 32'(cnt_log[81]), 32'd3);
        for (int k = 0; k < 6; k++) chk_frame($sformatf("full%0d", k), 2 + 40 * k, 8'hA0 + 8'(k));
        chk_idle("full", 242, 249);
        chk("full_ovf249", 32'(ovf_log[249]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
